// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART framed program image loader for instruction RAM
// Holds the CPU in reset until a checksum-valid image has been written.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 139,
  parameter int ADDR_W       = 11,
  parameter int MAX_WORDS    = 2048,
  parameter int TIMEOUT_CLKS = 16000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              uart_rx,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  logic [1:0]       r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_byte_valid;
  logic             r_frame_err;

  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [7:0]        r_csum;
  logic [ADDR_W:0]   r_idx;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_asm;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;

  logic [15:0] w_len_next;
  logic        w_active;

  assign w_len_next = {r_len[15:8], r_rx_shift};
  assign w_active   = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);

  // UART receiver: r_rx_s3 is the previous synchronised sample for edge detection.
  always_ff @(posedge CLK) begin
    r_byte_valid <= 1'b0;
    r_frame_err  <= 1'b0;
    if (RST) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: if (r_rx_s3 && !r_rx_s2) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= '0;
        end
        RX_START: if (r_rx_cnt == HALF_M1) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        RX_DATA: if (r_rx_cnt == BIT_M1) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        default: if (r_rx_cnt == BIT_M1) begin
          r_rx_cnt     <= '0;
          r_byte_valid <= r_rx_s2;
          r_frame_err  <= !r_rx_s2;
          r_rx_state   <= RX_IDLE;
        end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_csum      <= '0;
      r_idx       <= '0;
      r_bcnt      <= '0;
      r_asm       <= '0;
      r_to_cnt    <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      if (r_frame_err && r_state != S_IDLE) begin
        r_state <= S_ERR;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: if (r_byte_valid && r_rx_shift == 8'hA5) begin
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_csum     <= '0;
            r_idx      <= '0;
            r_bcnt     <= '0;
            r_state    <= S_LEN_HI;
          end
          S_LEN_HI: if (r_byte_valid) begin
            r_len[15:8] <= r_rx_shift;
            r_csum      <= r_csum ^ r_rx_shift;
            r_state     <= S_LEN_LO;
          end
          S_LEN_LO: if (r_byte_valid) begin
            r_len[7:0] <= r_rx_shift;
            r_csum     <= r_csum ^ r_rx_shift;
            if (32'(w_len_next) > MAX_WORDS) r_state <= S_ERR;
            else if (w_len_next == 16'd0)    r_state <= S_CSUM;
            else                             r_state <= S_DATA;
          end
          S_DATA: if (r_byte_valid) begin
            r_csum <= r_csum ^ r_rx_shift;
            r_bcnt <= r_bcnt + 2'd1;
            r_asm  <= {r_asm[15:0], r_rx_shift};
            if (r_bcnt == 2'd3) begin
              r_ram_we    <= 1'b1;
              r_ram_addr  <= r_idx[ADDR_W-1:0];
              r_ram_wdata <= {r_asm, r_rx_shift};
              r_idx       <= r_idx + {{ADDR_W{1'b0}}, 1'b1};
            end
          // Leave DATA only after the final strobe so ram_we stays inside DATA.
          end else if (r_ram_we && 32'(r_idx) == 32'(r_len)) begin
            r_state <= S_CSUM;
          end
          S_CSUM: if (r_byte_valid) begin
            if (r_rx_shift == r_csum) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else r_state <= S_ERR;
          end
          S_ERR: begin
            r_err      <= 1'b1;
            r_done     <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
      if (w_active && !r_byte_valid) begin
        if (r_to_cnt == TO_LAST) begin
          r_to_cnt <= '0;
          r_state  <= S_ERR;
        end else r_to_cnt <= r_to_cnt + TO_W'(1);
      end else r_to_cnt <= '0;
    end
  end

  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
// Frames are checked against a frame-level reference model of the load protocol.
module tb_uart_prog_loader;
  localparam int CPB = 8;
  localparam int AW  = 11;
  localparam int TO  = 400;
  localparam int MAXW = 2048;

  typedef logic [7:0]    byte_q_t[$];
  typedef logic [AW+31:0] wr_q_t[$];

  logic          CLK = 1'b0;
  logic          RST;
  logic          uart_rx;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;

  wr_q_t obs_q;
  logic  prev_we = 1'b0;
  int    we_multi = 0;
  int    bad_pair = 0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .MAX_WORDS(MAXW), .TIMEOUT_CLKS(TO)) dut (
    .CLK(CLK), .RST(RST), .uart_rx(uart_rx), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ram_we) begin
      obs_q.push_back({ram_addr, ram_wdata});
      if (prev_we) we_multi++;
    end
    prev_we = ram_we;
    if (done && cpu_hold) bad_pair++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge CLK);
    uart_rx = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  // Expected RAM writes and outcome derived from the frame bytes alone.
  task automatic model(input byte_q_t f, output wr_q_t exp, output bit ok);
    int len;
    logic [7:0] x;
    exp = {};
    ok  = 1'b0;
    len = int'({f[1], f[2]});
    if (len > MAXW) return;
    x = f[1] ^ f[2];
    for (int w = 0; w < len; w++) begin
      exp.push_back({AW'(w), f[3+4*w], f[4+4*w], f[5+4*w], f[6+4*w]});
      for (int k = 0; k < 4; k++) x = x ^ f[3+4*w+k];
    end
    ok = (f[3+4*len] == x);
  endtask

  task automatic run_frame(input string tag, input byte_q_t f);
    wr_q_t exp;
    bit ok;
    obs_q.delete();
    foreach (f[i]) send_byte(f[i], 1'b1);
    repeat (6) @(negedge CLK);
    model(f, exp, ok);
    check_eq({tag, "_nwr"}, obs_q.size(), exp.size());
    foreach (exp[i])
      if (i < obs_q.size()) check_eq($sformatf("%s_wr%0d", tag, i), obs_q[i], exp[i]);
    check_eq({tag, "_done"}, done, ok);
    check_eq({tag, "_err"}, err, !ok);
    check_eq({tag, "_hold"}, cpu_hold, !ok);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, ram_we, 1'b0);
    check_eq({tag, "_addr"}, ram_addr, '0);
    check_eq({tag, "_wdata"}, ram_wdata, '0);
    check_eq({tag, "_hold"}, cpu_hold, 1'b1);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_err"}, err, 1'b0);
  endtask

  byte_q_t good, badc, f;
  int      len;
  logic [7:0] cs, nb;

  initial begin
    good = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11,
            8'h11, 8'h00, 8'h00, 8'h00, 8'h02};
    badc = good;
    badc[11] = 8'h03;
    RST = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    run_frame("good", good);
    if (obs_q.size() == 2) begin
      check_eq("good_a0", obs_q[0], {11'd0, 32'h0000_0011});
      check_eq("good_a1", obs_q[1], {11'd1, 32'h1100_0000});
    end

    run_frame("badcs", badc);
    run_frame("recover", good);

    run_frame("oversize", {8'hA5, 8'h08, 8'h01});
    run_frame("len0", {8'hA5, 8'h00, 8'h00, 8'h00});

    uart_rx = 1'b0;
    repeat (2) @(negedge CLK);
    uart_rx = 1'b1;
    repeat (20) @(negedge CLK);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    check_eq("noise_done", done, 1'b1);
    run_frame("after_noise", good);

    obs_q.delete();
    foreach (good[i]) if (i < 4) send_byte(good[i], 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (6) @(negedge CLK);
    check_eq("frame_err", err, 1'b1);
    check_eq("frame_nwr", obs_q.size(), 0);
    check_eq("frame_hold", cpu_hold, 1'b1);

    obs_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (370) @(negedge CLK);
    check_eq("to_early_err", err, 1'b0);
    repeat (40) @(negedge CLK);
    check_eq("to_err", err, 1'b1);
    check_eq("to_nwr", obs_q.size(), 0);

    obs_q.delete();
    foreach (good[i]) if (i < 7) send_byte(good[i], 1'b1);
    repeat (4) @(negedge CLK);
    check_eq("mid_nwr", obs_q.size(), 1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_outputs("midrst");
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    run_frame("post_rst", good);

    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(0, 3);
      for (int n = $urandom_range(0, 2); n > 0; n--) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h3C;
        send_byte(nb, 1'b1);
      end
      f  = {8'hA5, 8'h00, 8'(len)};
      cs = 8'(len);
      for (int k = 0; k < 4 * len; k++) begin
        nb = 8'($urandom_range(0, 255));
        f.push_back(nb);
        cs = cs ^ nb;
      end
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      f.push_back(cs);
      run_frame($sformatf("rnd%0d", it), f);
    end

    check_eq("we_one_cycle", we_multi, 0);
    check_eq("done_hold_pair", bad_pair, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
